// File: rtl/apb_pkg.sv
// Shared definitions for the APB wait-state slave: bus widths, FSM states,
// error-response data and the address/direction error decode.
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] RDATA_ERR = 8'h00;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input logic              wr,
                                      input int unsigned       depth,
                                      input int unsigned       ro_base);
        return (32'(addr) >= depth) || (wr && (32'(addr) >= ro_base));
    endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// DEPTH x DATA_W storage with async clear, one write port and one combinational
// read port; out-of-range addresses are ignored on write and read back as zero.
module apb_slv_mem
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk_sys,
    input  logic              rst_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < DEPTH)) begin
            mem_d[waddr[IDX_W-1:0]] = wdata;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with address-range errors, a read-only upper window and
// optional wait states (compiled in only when APB_SLV_WAIT_EN is defined).
//
// state  | meaning
// IDLE   | no transfer in flight; a setup phase latches address, direction, data
// ACCESS | access phase; PREADY rises when the wait counter reaches zero
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RO_BASE     = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_LD == 4'd0);
    logic [3:0] cnt_q, cnt_d;
`else
    // Wait states compiled out: always respond in the first access cycle.
    localparam bit ZERO_WAIT = 1'b1 | (WAIT_CYCLES == 0);
`endif

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              resp_wr;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              setup;
    logic              access_ok;

    // In IDLE the response is built from the live bus (zero-wait case),
    // in ACCESS from the latched copies.
    assign setup      = PSEL && !PENABLE;
    assign access_ok  = PSEL && PENABLE;
    assign mem_raddr  = (state_q == IDLE) ? PADDR : addr_q;
    assign resp_wr    = (state_q == IDLE) ? PWRITE : write_q;
    assign resp_err   = addr_err(mem_raddr, resp_wr, DEPTH, RO_BASE);
    assign resp_rdata = (resp_err || resp_wr) ? RDATA_ERR : mem_rdata;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        mem_we    = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = RDATA_ERR;
                if (setup) begin
                    state_d = ACCESS;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = WAIT_LD;
`endif
                    if (ZERO_WAIT) begin
                        pready_d  = 1'b1;
                        pslverr_d = resp_err;
                        prdata_d  = resp_rdata;
                    end
                end
            end
            ACCESS: begin
                // Completion and protocol abort share the exit; only a clean
                // completion of a non-errored write touches storage.
                if (!access_ok || pready_q) begin
                    mem_we    = access_ok && write_q && !pslverr_q;
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = RDATA_ERR;
                end
`ifdef APB_SLV_WAIT_EN
                else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = resp_err;
                        prdata_d  = resp_rdata;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= RDATA_ERR;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    apb_slv_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_sys (PCLK),
        .rst_b   (PRESETn),
        .we      (mem_we),
        .waddr   (addr_q),
        .wdata   (wdata_q),
        .raddr   (mem_raddr),
        .rdata   (mem_rdata)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule
